// File: rtl/sound_sequencer_pkg.sv
// Shared types and constants for the sound sequencer: FSM states, tune codes
// and the half-period tables for both tunes (full-scale 50 MHz values).
package sound_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [9:0] TUNE_LOSE = 10'd0;
  localparam logic [9:0] TUNE_WIN  = 10'd1;

  // Element [0] is the first note played; a zero entry is a rest.
  localparam logic [3:0][16:0] WIN_HP  = {17'd23878, 17'd31888, 17'd37936, 17'd47801};
  localparam logic [3:0][16:0] LOSE_HP = {17'd0,     17'd95420, 17'd75758, 17'd63776};

  function automatic logic [16:0] table_entry(input logic win, input logic [1:0] idx);
    logic [16:0] entry;
    entry = win ? WIN_HP[idx] : LOSE_HP[idx];
    return entry;
  endfunction

endpackage

// File: rtl/sound_sequencer_if.sv
// Controller-to-sequencer bundle: request inputs, audio/status outputs and
// the FSM state exposed for observation.
interface sound_sequencer_if;
  // Request protocol: play_req is a level; only its 0->1 transition while the
  // sequencer is idle starts a tune, and tune_sel is captured on that cycle.
  // There is no acknowledge: busy rises the next cycle, done pulses at the end.
  logic                  play_req;
  logic [9:0]            tune_sel;
  logic                  mute;
  logic                  audio_out;
  logic                  busy;
  logic                  done;
  logic [1:0]            note_idx;
  sound_pkg::state_t     state;

  modport master (
    output play_req, tune_sel, mute,
    input  audio_out, busy, done, note_idx, state
  );

  modport slave (
    input  play_req, tune_sel, mute,
    output audio_out, busy, done, note_idx, state
  );
endinterface

// File: rtl/sound_sequencer_tone_gen.sv
// Square-wave divider: toggles its output every half_period cycles while
// enabled; restart or a zero half-period parks it low with the count cleared.
module tone_gen (
    input  logic        clk,
    input  logic        resetN,
    input  logic [16:0] half_period,
    input  logic        enable,
    input  logic        restart,
    output logic        wave
);

    logic [16:0] cnt;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt  <= '0;
            wave <= 1'b0;
        end else if (restart || !enable || half_period == 17'd0) begin
            cnt  <= '0;
            wave <= 1'b0;
        end else if (cnt == half_period - 17'd1) begin
            cnt  <= '0;
            wave <= ~wave;
        end else begin
            cnt <= cnt + 17'd1;
        end
    end

endmodule

// File: rtl/sound_sequencer.sv
// Four-note tune player: a rising edge on play_req starts the WIN or LOSE
// tune, notes separated by optional silent gaps, with a done pulse at the end.
module sound_sequencer #(
    parameter int NOTE_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 2_500_000,
    parameter int TONE_SHIFT  = 0
) (
    input  logic              clk,
    input  logic              resetN,
    sound_sequencer_if.slave  bus
);
    import sound_pkg::*;

    localparam logic [23:0] NOTE_LAST = 24'(NOTE_CYCLES - 1);
    localparam logic [23:0] GAP_LAST  = 24'(GAP_CYCLES - 1);
    localparam bit          HAS_GAP   = (GAP_CYCLES != 0);

    state_t      state;
    logic        play_q;
    logic        armed;
    logic        start;
    logic        tune_valid;
    logic        tune_win;
    logic [23:0] dur_cnt;
    logic [1:0]  note_idx;
    logic        busy;
    logic        done;
    logic        note_end;
    logic        tone_en;
    logic        tone_restart;
    logic [16:0] half_period;
    logic        wave;

    // armed stays low for the first cycle after reset so a play_req that is
    // already high at release is absorbed into play_q instead of firing.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            play_q <= 1'b0;
            armed  <= 1'b0;
        end else begin
            play_q <= bus.play_req;
            armed  <= 1'b1;
        end
    end

    assign start      = armed && bus.play_req && !play_q;
    assign tune_valid = (bus.tune_sel == TUNE_LOSE) || (bus.tune_sel == TUNE_WIN);

    assign note_end     = (state == ST_PLAY) && (dur_cnt == NOTE_LAST);
    assign tone_en      = (state == ST_PLAY);
    assign tone_restart = (state != ST_PLAY) || note_end;
    assign half_period  = table_entry(tune_win, note_idx) >> TONE_SHIFT;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= ST_IDLE;
            tune_win <= 1'b0;
            note_idx <= 2'd0;
            dur_cnt  <= 24'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start && tune_valid) begin
                        state    <= ST_PLAY;
                        tune_win <= (bus.tune_sel == TUNE_WIN);
                        note_idx <= 2'd0;
                        dur_cnt  <= 24'd0;
                        busy     <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (dur_cnt == NOTE_LAST) begin
                        dur_cnt <= 24'd0;
                        if (note_idx == 2'd3) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (HAS_GAP) begin
                            state <= ST_GAP;
                        end else begin
                            note_idx <= note_idx + 2'd1;
                        end
                    end else begin
                        dur_cnt <= dur_cnt + 24'd1;
                    end
                end
                ST_GAP: begin
                    if (dur_cnt == GAP_LAST) begin
                        state    <= ST_PLAY;
                        note_idx <= note_idx + 2'd1;
                        dur_cnt  <= 24'd0;
                    end else begin
                        dur_cnt <= dur_cnt + 24'd1;
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    done     <= 1'b0;
                    note_idx <= 2'd0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    tone_gen u_tone_gen (
        .clk         (clk),
        .resetN      (resetN),
        .half_period (half_period),
        .enable      (tone_en),
        .restart     (tone_restart),
        .wave        (wave)
    );

    assign bus.audio_out = wave & ~bus.mute;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.note_idx  = note_idx;
    assign bus.state     = state;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer with scaled timing (64-cycle notes,
// 4-cycle gaps, half-periods shifted right by 12).
module tb_sound_sequencer;
  import sound_pkg::*;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  sound_sequencer_if bus();

  sound_sequencer #(
    .NOTE_CYCLES (64),
    .GAP_CYCLES  (4),
    .TONE_SHIFT  (12)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  // Hand-shifted half-periods (entry >> 12).
  int hp_win[4]  = '{11, 9, 7, 5};
  int hp_lose[4] = '{15, 18, 23, 0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Each note slot is 64 play cycles plus 4 gap cycles.
  function automatic logic exp_audio(input logic win, input int s, input logic m);
    int k;
    int r;
    int hp;
    k = s / 68;
    r = s % 68;
    if (k > 3) return 1'b0;
    hp = win ? hp_win[k] : hp_lose[k];
    if (m || r >= 64 || hp == 0) return 1'b0;
    return ((r / hp) % 2) == 1;
  endfunction

  task automatic run_tune(input logic win, input logic m, input int retrig,
                          output int len, output int audio_err, output int idx_err,
                          output int rest_high, output int done_during,
                          output logic done_after, output logic done_cleared);
    int s;
    bus.tune_sel = win ? 10'd1 : 10'd0;
    bus.mute     = m;
    bus.play_req = 1'b1;
    step();
    s = 0;
    audio_err = 0;
    idx_err = 0;
    rest_high = 0;
    done_during = 0;
    while (bus.busy === 1'b1 && s < 1000) begin
      if (bus.audio_out !== exp_audio(win, s, m)) audio_err++;
      if (bus.note_idx !== 2'(s / 68)) idx_err++;
      if (s >= 204 && bus.audio_out === 1'b1) rest_high++;
      if (bus.done !== 1'b0) done_during++;
      if (s == 5) bus.play_req = 1'b0;
      if (retrig > 0 && s == retrig - 1) bus.play_req = 1'b1;
      s++;
      step();
    end
    len = s;
    done_after = bus.done;
    bus.play_req = 1'b0;
    bus.mute = 1'b0;
    step();
    done_cleared = (bus.done === 1'b0) && (bus.busy === 1'b0);
    step();
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    bus.play_req = 1'b0;
    bus.tune_sel = 10'd0;
    bus.mute = 1'b0;
    #12;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.audio_out !== 1'b0) begin errors++; $display("FAIL reset_audio: got %b want 0", bus.audio_out); end
    checks++; if (bus.note_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", bus.note_idx); end
    checks++; if (bus.state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.state); end
    step();
    resetN = 1'b1;
    step();
    step();
  endtask

  task automatic test_win();
    int len, ae, ie, rh, dd;
    logic da, dc;
    run_tune(1'b1, 1'b0, 0, len, ae, ie, rh, dd, da, dc);
    checks++; if (len !== 268) begin errors++; $display("FAIL win_len: got %0d want 268", len); end
    checks++; if (ae !== 0) begin errors++; $display("FAIL win_audio: got %0d bad samples want 0", ae); end
    checks++; if (ie !== 0) begin errors++; $display("FAIL win_idx: got %0d bad samples want 0", ie); end
    checks++; if (dd !== 0) begin errors++; $display("FAIL win_done_early: got %0d want 0", dd); end
    checks++; if (da !== 1'b1) begin errors++; $display("FAIL win_done_pulse: got %b want 1", da); end
    checks++; if (dc !== 1'b1) begin errors++; $display("FAIL win_done_one_cycle: got %b want 1", dc); end
  endtask

  task automatic test_lose();
    int len, ae, ie, rh, dd;
    logic da, dc;
    run_tune(1'b0, 1'b0, 0, len, ae, ie, rh, dd, da, dc);
    checks++; if (len !== 268) begin errors++; $display("FAIL lose_len: got %0d want 268", len); end
    checks++; if (ae !== 0) begin errors++; $display("FAIL lose_audio: got %0d bad samples want 0", ae); end
    checks++; if (ie !== 0) begin errors++; $display("FAIL lose_idx: got %0d bad samples want 0", ie); end
    checks++; if (rh !== 0) begin errors++; $display("FAIL lose_rest: got %0d high samples want 0", rh); end
    checks++; if (da !== 1'b1 || dc !== 1'b1) begin errors++; $display("FAIL lose_done: got %b%b want 11", da, dc); end
  endtask

  task automatic test_retrigger();
    int len, ae, ie, rh, dd;
    logic da, dc;
    run_tune(1'b1, 1'b0, 100, len, ae, ie, rh, dd, da, dc);
    checks++; if (len !== 268) begin errors++; $display("FAIL retrig_len: got %0d want 268", len); end
    checks++; if (ie !== 0) begin errors++; $display("FAIL retrig_idx: got %0d bad samples want 0", ie); end
    checks++; if (ae !== 0) begin errors++; $display("FAIL retrig_audio: got %0d bad samples want 0", ae); end
    checks++; if (dd !== 0 || da !== 1'b1) begin errors++; $display("FAIL retrig_done: got early=%0d end=%b want 0/1", dd, da); end
  endtask

  task automatic test_invalid();
    int busy_hi, done_hi;
    busy_hi = 0;
    done_hi = 0;
    bus.tune_sel = 10'd5;
    bus.play_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.busy !== 1'b0) busy_hi++;
      if (bus.done !== 1'b0) done_hi++;
    end
    checks++; if (busy_hi !== 0) begin errors++; $display("FAIL invalid_busy: got %0d high cycles want 0", busy_hi); end
    checks++; if (done_hi !== 0) begin errors++; $display("FAIL invalid_done: got %0d high cycles want 0", done_hi); end
    bus.play_req = 1'b0;
    step();
  endtask

  task automatic test_mid_reset();
    int busy_hi;
    busy_hi = 0;
    bus.tune_sel = 10'd1;
    bus.play_req = 1'b1;
    step();
    for (int i = 0; i < 150; i++) step();
    resetN = 1'b0;
    #1;
    checks++; if (bus.audio_out !== 1'b0) begin errors++; $display("FAIL midrst_audio: got %b want 0", bus.audio_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.note_idx !== 2'd0) begin errors++; $display("FAIL midrst_idx: got %0d want 0", bus.note_idx); end
    checks++; if (bus.state !== ST_IDLE) begin errors++; $display("FAIL midrst_state: got %0d want 0", bus.state); end
    step();
    step();
    resetN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.busy !== 1'b0) busy_hi++;
    end
    checks++; if (busy_hi !== 0) begin errors++; $display("FAIL midrst_no_restart: got %0d busy cycles want 0", busy_hi); end
    bus.play_req = 1'b0;
    step();
  endtask

  task automatic test_after_reset();
    int len, ae, ie, rh, dd;
    logic da, dc;
    run_tune(1'b1, 1'b0, 0, len, ae, ie, rh, dd, da, dc);
    checks++; if (len !== 268 || ae !== 0) begin errors++; $display("FAIL post_reset_tune: got len=%0d audio_err=%0d want 268/0", len, ae); end
  endtask

  task automatic test_mute();
    int len, ae, ie, rh, dd;
    logic da, dc;
    run_tune(1'b1, 1'b1, 0, len, ae, ie, rh, dd, da, dc);
    checks++; if (len !== 268) begin errors++; $display("FAIL mute_len: got %0d want 268", len); end
    checks++; if (ae !== 0) begin errors++; $display("FAIL mute_audio: got %0d bad samples want 0", ae); end
    checks++; if (ie !== 0) begin errors++; $display("FAIL mute_idx: got %0d bad samples want 0", ie); end
    checks++; if (da !== 1'b1 || dc !== 1'b1) begin errors++; $display("FAIL mute_done: got %b%b want 11", da, dc); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_win();
    test_lose();
    test_retrigger();
    test_invalid();
    test_mid_reset();
    test_after_reset();
    test_mute();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sound_sequencer.md
SOUND_SEQUENCER -- requirements
Module: sound_sequencer

Interface
REQ-001 Parameter NOTE_CYCLES, default 12_500_000, gives the length of each note in clk cycles (0.25 s at 50 MHz).
REQ-002 Parameter GAP_CYCLES, default 2_500_000, gives the silent gap between notes in clk cycles.
REQ-003 Parameter TONE_SHIFT, default 0, sets the right-shift applied to every half-period table entry (used for simulation scaling).
REQ-004 Port clk, input, 1 bit: single system clock; all state is on its rising edge.
REQ-005 Port resetN, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port play_req, input, 1 bit: level, driven by the game controller's enable_sound; its rising edge requests a tune.
REQ-007 Port tune_sel, input, 10 bits: tune code driven by the controller's sound_freq_out; 0 = LOSE tune, 1 = WIN tune, any other value = invalid.
REQ-008 Port mute, input, 1 bit: when 1, forces audio_out low; sequencing continues unchanged.
REQ-009 Port audio_out, output, 1 bit: square-wave speaker drive.
REQ-010 Port busy, output, 1 bit: 1 while the state is PLAY or GAP.
REQ-011 Port done, output, 1 bit: one-cycle pulse when a tune completes.
REQ-012 Port note_idx, output, 2 bits: index of the current note (0-3).

Function
REQ-013 Rising-edge detection: a registered copy of play_req is kept, and an edge is play_req=1 with the previous value 0.
REQ-014 FSM states are IDLE, PLAY, GAP and DONE.
REQ-015 IDLE to PLAY on a detected edge with tune_sel 0 or 1; tune_sel is latched on that cycle, so later changes have no effect.
REQ-016 An edge with an invalid tune_sel is ignored: the FSM stays in IDLE and done is not pulsed.
REQ-017 Latency: with an edge at cycle N, the FSM is in PLAY with note_idx=0 at cycle N+1, and audio_out=0 at entry.
REQ-018 PLAY lasts exactly NOTE_CYCLES cycles; audio_out toggles every half-period cycles, where half-period = table entry >> TONE_SHIFT.
REQ-019 A half-period of 0 (REST) holds audio_out at 0 for the whole note.
REQ-020 At the end of notes 0-2 the FSM enters GAP; GAP lasts GAP_CYCLES cycles with audio_out=0, then returns to PLAY with note_idx incremented and the tone counter reloaded.
REQ-021 At the end of note 3 the FSM enters DONE with no gap; DONE lasts one cycle with done=1 and busy=0, then the FSM returns to IDLE.
REQ-022 Edges detected in PLAY, GAP or DONE are ignored and not queued.
REQ-023 GAP_CYCLES=0 skips GAP entirely: the FSM goes directly to the next note.
REQ-024 Note duration counter is 24 bits and tone counter is 17 bits; both count up and clear on every note or state change; no wrap occurs within a note.
REQ-025 WIN tune (half-periods at 50 MHz): C5 47801, E5 37936, G5 31888, C6 23878.
REQ-026 LOSE tune (half-periods at 50 MHz): G4 63776, E4 75758, C4 95420, REST 0.

Reset
REQ-027 Asserting resetN low, including mid-tune, immediately forces: state IDLE, audio_out=0, busy=0, done=0, note_idx=0, all counters 0, edge register 0.
REQ-028 After reset release, a play_req already high does not count as an edge; a fresh 0-to-1 transition is required.

Structure
REQ-029 Package sound_pkg holds the state enum, the TUNE_LOSE=0 and TUNE_WIN=1 codes, and both 4-entry half-period tables as 17-bit constants.
REQ-030 Sub-module tone_gen (inputs: half-period, enable, restart; output: square wave) implements the toggle divider; everything else lives in sound_sequencer.

Verification
REQ-031 All scenarios use NOTE_CYCLES=64, GAP_CYCLES=4, TONE_SHIFT=12.
REQ-032 WIN tune: play_req rises with tune_sel=1 -> busy high for exactly 268 cycles; note 0 toggles audio_out every 11 cycles; done pulses once on the following cycle.
REQ-033 LOSE tune: play_req rises with tune_sel=0 -> note 3 (REST) holds audio_out=0 for 64 cycles; done pulses after 268 busy cycles.
REQ-034 Retrigger: a second play_req edge at busy cycle 100 -> no restart, note_idx continues, total busy length stays 268.
REQ-035 Invalid code: play_req edge with tune_sel=5 -> busy stays 0 and done stays 0.
REQ-036 Mid-tune reset: resetN driven low at busy cycle 150 -> audio_out, busy and note_idx are 0 immediately; play_req held high through the release causes no new tune.
REQ-037 Mute: mute=1 for the whole WIN tune -> audio_out stays 0 while busy and done timing are identical to the unmuted run.
